// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  localparam int LSU_WORD_BYTES = 4;
  localparam int LSU_OFF_W      = $clog2(LSU_WORD_BYTES);

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // A reserved size is treated as a fault whenever alignment checking is enabled.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [LSU_OFF_W-1:0] off);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = off[0];
      WORD:    bad = (off != '0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0]          rd_word,
  input  logic [31:0]          wdata,
  input  lsu_size_e            size,
  input  logic [LSU_OFF_W-1:0] offset,
  input  logic                 is_signed,
  output logic [31:0]          load_data,
  output logic [31:0]          store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = rd_word[{offset, 3'b000} +: 8];
    lane_h     = rd_word[{offset[1], 4'b0000} +: 16];
    load_data  = rd_word;
    store_word = wdata;
    case (size)
      BYTE: begin
        load_data  = {{24{is_signed & lane_b[7]}}, lane_b};
        store_word = rd_word;
        store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      HALF: begin
        load_data  = {{16{is_signed & lane_h[15]}}, lane_h};
        store_word = rd_word;
        store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rd_word;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// Load/store unit driving a word-only memory; sub-word stores are read-modify-write.
// Optional alignment fault detection is enabled with `define LSU_ALIGN_CHECK_EN.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  lsu_size_e         size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_buf_q, rd_buf_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  lsu_size_e   req_size_eff;
  logic        req_fault;
  logic [31:0] align_word;
  logic [31:0] load_data;
  logic [31:0] store_word;

  always_comb begin
    req_size_eff = lsu_size_e'(req_size);
`ifndef LSU_ALIGN_CHECK_EN
    if (req_size_eff == RSVD) req_size_eff = WORD;
`endif
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign req_fault = lsu_misaligned(lsu_size_e'(req_size), req_addr[LSU_OFF_W-1:0]);
`else
  assign req_fault = 1'b0;
`endif

  // Loads extract straight from the live read data so the result is ready at the end of READ.
  assign align_word = (state_q == READ) ? mem_read_data : rd_buf_q;

  lsu_lane_align u_align (
    .rd_word    (align_word),
    .wdata      (wdata_q),
    .size       (size_q),
    .offset     (addr_q[LSU_OFF_W-1:0]),
    .is_signed  (signed_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_buf_d    = rd_buf_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          size_d      = req_size_eff;
          signed_d    = req_signed;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b0;
          if (req_fault) begin
            rsp_error_d = 1'b1;
            state_d     = RESP;
          end else if (req_write && (req_size_eff == WORD)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        rd_buf_d = mem_read_data;
        if (write_q) begin
          state_d = WRITE;
        end else begin
          rsp_rdata_d = load_data;
          state_d     = RESP;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        rsp_rdata_d = '0;
        rsp_error_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      size_q      <= BYTE;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_buf_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_buf_q    <= rd_buf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Decoded from the async-reset state so reset drops the write strobe immediately.
  always_comb begin
    mem_write_enable = 1'b0;
    mem_adress       = '0;
    mem_write_data   = '0;
    if (state_q == READ) begin
      mem_adress = {addr_q[ADDR_W-1:LSU_OFF_W], {LSU_OFF_W{1'b0}}};
    end else if (state_q == WRITE) begin
      mem_write_enable = 1'b1;
      mem_adress       = {addr_q[ADDR_W-1:LSU_OFF_W], {LSU_OFF_W{1'b0}}};
      mem_write_data   = store_word;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_lsu_master.sv
// Self-checking bench for lsu_master: directed vector table, reset abort sequence and random traffic vs a reference model.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_write_enable;
  logic [31:0] mem_adress, mem_write_data, mem_read_data;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        bk_we = 1'b0;
  logic [5:0]  bk_idx = '0;
  logic [31:0] bk_data = '0;

  always #5 clk = ~clk;

  lsu_master #(.ADDR_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_error        (rsp_error),
    .mem_write_enable (mem_write_enable),
    .mem_adress       (mem_adress),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  assign mem_read_data = mem[mem_adress[7:2]];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_adress[7:2]] <= mem_write_data;
    else if (bk_we)       mem[bk_idx] <= bk_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    bk_idx  = idx;
    bk_data = val;
    bk_we   = 1'b1;
    ref_mem[idx] = val;
    @(negedge clk);
    bk_we = 1'b0;
  endtask

  // Observations of the most recent request, cycles counted from the accept cycle T.
  int          obs_lat;
  logic [31:0] obs_rdata, obs_we_addr, obs_we_data, obs_addr1;
  logic        obs_err;
  logic [8:0]  obs_we_mask, obs_act_mask;

  // Called at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    obs_lat = 0; obs_rdata = '0; obs_err = 1'b0; obs_we_mask = '0; obs_act_mask = '0;
    obs_we_addr = '0; obs_we_data = '0; obs_addr1 = '0;
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    for (int c = 1; c <= 8 && obs_lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) obs_addr1 = mem_adress;
      if (mem_write_enable) begin
        obs_we_mask[c] = 1'b1;
        obs_we_addr    = mem_adress;
        obs_we_data    = mem_write_data;
      end
      if (mem_write_enable || mem_adress != 0) obs_act_mask[c] = 1'b1;
      if (rsp_valid) begin
        obs_lat   = c;
        obs_rdata = rsp_rdata;
        obs_err   = rsp_error;
      end
      // Request inputs are don't-care while busy; scramble them.
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3)); req_addr = $urandom; req_wdata = $urandom;
    end
    req_valid = 1'b0;
    if (obs_lat == 0) begin
      checks++; failures++;
      $display("FAIL rsp_timeout actual=none required=rsp_valid within 8 cycles");
    end
    @(negedge clk);
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
    chk("ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        pre_en;
    logic [31:0] pre_val;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_mem;
  } vec_t;

  function automatic vec_t mk(input logic pe, input logic [31:0] pv, input logic w, input logic [1:0] sz,
                              input logic sg, input logic [31:0] a, input logic [31:0] wd, input int lat,
                              input logic [31:0] rd, input logic er, input logic [31:0] em);
    vec_t v;
    v.pre_en = pe; v.pre_val = pv; v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd;
    v.exp_lat = lat; v.exp_rdata = rd; v.exp_err = er; v.exp_mem = em;
    return v;
  endfunction

  // Reference model: byte-lane arithmetic on whole words.
  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input int nb, input int off, input bit sg);
    longint v;
    v = longint'((64'(word) >> (8 * off)) & ((64'd1 << (8 * nb)) - 1));
    if (sg && nb < 4 && v >= longint'(64'd1 << (8 * nb - 1))) v = v - longint'(64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] wd, input int nb, input int off);
    logic [63:0] mask;
    mask = ((64'd1 << (8 * nb)) - 1) << (8 * off);
    return (word & ~mask[31:0]) | ((wd << (8 * off)) & mask[31:0]);
  endfunction

  vec_t vt[13];

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h12345678;

    // Reset held with a pending request: block must stay idle and quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_ready[%0d]", i), 32'(req_ready), 32'd1);
      chk($sformatf("reset_rsp_valid[%0d]", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("reset_we[%0d]", i), 32'(mem_write_enable), 32'd0);
    end
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_error", 32'(rsp_error), 32'd0);
    chk("reset_adress", mem_adress, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 64; i++) poke(6'(i), $urandom);

    vt[0]  = mk(1, 32'h0,        1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0,        0, 32'hDEADBEEF);
    vt[1]  = mk(0, 32'h0,        0, 2'd2, 0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    vt[2]  = mk(1, 32'h11223344, 1, 2'd0, 0, 32'h11, 32'hFFFFFFAA, 3, 32'h0,        0, 32'h1122AA44);
    vt[3]  = mk(1, 32'h80FF0000, 0, 2'd0, 1, 32'h13, 32'h0,        2, 32'hFFFFFF80, 0, 32'h80FF0000);
    vt[4]  = mk(0, 32'h0,        0, 2'd0, 0, 32'h13, 32'h0,        2, 32'h00000080, 0, 32'h80FF0000);
    vt[5]  = mk(0, 32'h0,        0, 2'd1, 1, 32'h12, 32'h0,        2, 32'hFFFF80FF, 0, 32'h80FF0000);
    vt[6]  = mk(0, 32'h0,        0, 2'd1, 0, 32'h12, 32'h0,        2, 32'h000080FF, 0, 32'h80FF0000);
    vt[8]  = mk(1, 32'hCAFEF00D, 1, 2'd1, 0, 32'h16, 32'hABCD1234, 3, 32'h0,        0, 32'h1234F00D);
    vt[10] = mk(1, 32'h0,        1, 2'd0, 0, 32'h18, 32'h1234567F, 3, 32'h0,        0, 32'h0000007F);
    vt[11] = mk(0, 32'h0,        0, 2'd0, 1, 32'h18, 32'h0,        2, 32'h0000007F, 0, 32'h0000007F);
`ifdef LSU_ALIGN_CHECK_EN
    vt[7]  = mk(0, 32'h0,        0, 2'd2, 0, 32'h12, 32'h0,        1, 32'h0,        1, 32'h80FF0000);
    vt[9]  = mk(0, 32'h0,        0, 2'd3, 0, 32'h14, 32'h0,        1, 32'h0,        1, 32'h1234F00D);
    vt[12] = mk(0, 32'h0,        1, 2'd2, 0, 32'h1A, 32'h01020304, 1, 32'h0,        1, 32'h0000007F);
`else
    vt[7]  = mk(0, 32'h0,        0, 2'd2, 0, 32'h12, 32'h0,        2, 32'h80FF0000, 0, 32'h80FF0000);
    vt[9]  = mk(0, 32'h0,        0, 2'd3, 0, 32'h14, 32'h0,        2, 32'h1234F00D, 0, 32'h1234F00D);
    vt[12] = mk(0, 32'h0,        1, 2'd2, 0, 32'h1A, 32'h01020304, 2, 32'h0,        0, 32'h01020304);
`endif

    for (int i = 0; i < 13; i++) begin
      logic [8:0] exp_we, exp_act;
      if (vt[i].pre_en) poke(vt[i].a[7:2], vt[i].pre_val);
      issue(vt[i].w, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd);
      exp_we  = (vt[i].w && !vt[i].exp_err) ? 9'(1 << (vt[i].exp_lat - 1)) : 9'd0;
      exp_act = vt[i].exp_err ? 9'd0 : 9'((1 << vt[i].exp_lat) - 2);
      chk($sformatf("vec%0d_latency", i), 32'(obs_lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_rdata", i), obs_rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d_error", i), 32'(obs_err), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_we_cycles", i), 32'(obs_we_mask), 32'(exp_we));
      chk($sformatf("vec%0d_mem_active_cycles", i), 32'(obs_act_mask), 32'(exp_act));
      if (!vt[i].exp_err) chk($sformatf("vec%0d_adress_t1", i), obs_addr1, vt[i].a & ~32'd3);
      if (exp_we != 0) chk($sformatf("vec%0d_we_data", i), obs_we_data, vt[i].exp_mem);
      chk($sformatf("vec%0d_mem_word", i), mem[vt[i].a[7:2]], vt[i].exp_mem);
    end

    // Reset during the READ of a byte store must abort without touching memory.
    poke(6'h08, 32'h11223344);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000AA;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_read_adress", mem_adress, 32'h20);
    chk("abort_read_we", 32'(mem_write_enable), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_we_async", 32'(mem_write_enable), 32'd0);
    chk("abort_ready_async", 32'(req_ready), 32'd1);
    chk("abort_adress_async", mem_adress, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_hold_we[%0d]", i), 32'(mem_write_enable), 32'd0);
      chk($sformatf("abort_hold_rsp[%0d]", i), 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_mem_unchanged", mem[8], 32'h11223344);
    chk("abort_ready_after", 32'(req_ready), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    chk("abort_next_latency", 32'(obs_lat), 32'd2);
    chk("abort_next_rdata", obs_rdata, 32'h11223344);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 64; i++) poke(6'(i), $urandom);
    for (int i = 0; i < 300; i++) begin
      logic        w, sg, fault;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp_rd, old_word, exp_word;
      int          nb, off, exp_lat;
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      wd = $urandom;
      nb = nbytes_of(sz);
`ifdef LSU_ALIGN_CHECK_EN
      fault = (sz == 2'd3) || ((a % nb) != 0);
`else
      fault = 1'b0;
`endif
      off      = (int'(a % 4) / nb) * nb;
      old_word = ref_mem[a[7:2]];
      exp_rd   = '0;
      exp_word = old_word;
      if (fault)            exp_lat = 1;
      else if (!w)          exp_lat = 2;
      else if (nb == 4)     exp_lat = 2;
      else                  exp_lat = 3;
      if (!fault && !w) exp_rd = model_load(old_word, nb, off, sg);
      if (!fault && w)  exp_word = model_store(old_word, wd, nb, off);
      ref_mem[a[7:2]] = exp_word;
      issue(w, sz, sg, a, wd);
      chk($sformatf("rnd%0d_latency", i), 32'(obs_lat), 32'(exp_lat));
      chk($sformatf("rnd%0d_rdata", i), obs_rdata, exp_rd);
      chk($sformatf("rnd%0d_error", i), 32'(obs_err), 32'(fault));
      chk($sformatf("rnd%0d_mem_word", i), mem[a[7:2]], exp_word);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
